// File: rtl/serial_deglitch_multi.sv
// Multi-channel serial deglitcher: per-line saturating counter with hysteresis
// and registered edge pulses. Define SERIAL_DEGLITCH_SYNC_EN for 2-flop input sync.
module serial_deglitch_multi #(
    parameter int                     NumChannels = 4,
    parameter int                     Size        = 4,
    parameter logic [NumChannels-1:0] ResetValue  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [NumChannels-1:0] d_i,
    output logic [NumChannels-1:0] q_o,
    output logic [NumChannels-1:0] rise_o,
    output logic [NumChannels-1:0] fall_o
);

    localparam int              CntW  = $clog2(Size + 1);
    localparam logic [CntW-1:0] SizeC = CntW'(Size);
    localparam logic [CntW-1:0] OneC  = CntW'(1);

    logic [NumChannels-1:0]           d_s;
    logic [NumChannels-1:0][CntW-1:0] cnt_q;
    logic [NumChannels-1:0][CntW-1:0] cnt_d;
    logic [NumChannels-1:0]           q_d;

    function automatic logic [CntW-1:0] cnt_init(input logic b);
        return b ? SizeC : '0;
    endfunction

`ifdef SERIAL_DEGLITCH_SYNC_EN
    logic [NumChannels-1:0] sync1_q;
    logic [NumChannels-1:0] sync2_q;

    // Two-flop synchroniser; free-running, only rst_i clears it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= ResetValue;
            sync2_q <= ResetValue;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign d_s = sync2_q;
`else
    assign d_s = d_i;
`endif

    // Next counter value with explicit saturation, then hysteresis on q
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_o;
        for (int c = 0; c < NumChannels; c++) begin
            if (en_i) begin
                if (d_s[c] && (cnt_q[c] != SizeC)) begin
                    cnt_d[c] = cnt_q[c] + OneC;
                end else if (!d_s[c] && (cnt_q[c] != '0)) begin
                    cnt_d[c] = cnt_q[c] - OneC;
                end
                if (cnt_d[c] == SizeC) begin
                    q_d[c] = 1'b1;
                end else if (cnt_d[c] == '0) begin
                    q_d[c] = 1'b0;
                end
            end
        end
    end

    // State update: reset/clear restore defaults, pulses only on enabled edges
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= cnt_init(ResetValue[c]);
            end
            q_o    <= ResetValue;
            rise_o <= '0;
            fall_o <= '0;
        end else if (clr_i) begin
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= cnt_init(ResetValue[c]);
            end
            q_o    <= ResetValue;
            rise_o <= '0;
            fall_o <= '0;
        end else if (en_i) begin
            cnt_q  <= cnt_d;
            q_o    <= q_d;
            rise_o <= q_d & ~q_o;
            fall_o <= ~q_d & q_o;
        end else begin
            rise_o <= '0;
            fall_o <= '0;
        end
    end

endmodule

// File: tb/tb_serial_deglitch_multi.sv
// Bench for serial_deglitch_multi: directed vector table, hand sequences,
// and a per-channel reference model; adapts to SERIAL_DEGLITCH_SYNC_EN.
module tb_serial_deglitch_multi;

    localparam int         SIZE = 4;
    localparam logic [3:0] RV   = 4'b0101;
`ifdef SERIAL_DEGLITCH_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] f;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       en;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;

    logic       clr1;
    logic       en1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] r1;
    logic [0:0] f1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];

    int         mcnt[4];
    logic [3:0] mq;
    logic [3:0] mr;
    logic [3:0] mf;
    logic [3:0] ms1;
    logic [3:0] ms2;

    serial_deglitch_multi #(
        .NumChannels(4),
        .Size(SIZE),
        .ResetValue(RV)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(clr),
        .en_i(en),
        .d_i(d),
        .q_o(q),
        .rise_o(rise),
        .fall_o(fall)
    );

    serial_deglitch_multi #(
        .NumChannels(1),
        .Size(1),
        .ResetValue(1'b0)
    ) u_s1 (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(clr1),
        .en_i(en1),
        .d_i(d1),
        .q_o(q1),
        .rise_o(r1),
        .fall_o(f1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic [3:0] dv);
        en  = e;
        clr = c;
        d   = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic c, input logic [3:0] dv,
                       input logic [3:0] eq, input logic [3:0] er,
                       input logic [3:0] ef);
        vec_t v;
        v.en  = e;
        v.clr = c;
        v.d   = dv;
        v.q   = eq;
        v.r   = er;
        v.f   = ef;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) mcnt[c] = RV[c] ? SIZE : 0;
        mq  = RV;
        mr  = '0;
        mf  = '0;
        ms1 = RV;
        ms2 = RV;
    endtask

    task automatic model_step(input logic e, input logic c,
                              input logic [3:0] dv);
        logic [3:0] din;
        logic       nq;
        int         n;
        din = dv;
`ifdef SERIAL_DEGLITCH_SYNC_EN
        din = ms2;
        ms2 = ms1;
        ms1 = dv;
`endif
        if (c) begin
            for (int k = 0; k < 4; k++) mcnt[k] = RV[k] ? SIZE : 0;
            mq = RV;
            mr = '0;
            mf = '0;
        end else if (!e) begin
            mr = '0;
            mf = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                n = mcnt[k];
                if (din[k] && n < SIZE) n++;
                else if (!din[k] && n > 0) n--;
                if (n == SIZE) nq = 1'b1;
                else if (n == 0) nq = 1'b0;
                else nq = mq[k];
                mr[k] = nq & ~mq[k];
                mf[k] = ~nq & mq[k];
                mq[k] = nq;
                mcnt[k] = n;
            end
        end
    endtask

    initial begin
        logic [3:0] dsel;
        logic [3:0] dv;
        logic       e;
        logic       c;
        logic       pat[12];
        logic       eq1;
        logic       pq1;

        rst  = 1'b1;
        clr  = 1'b0;
        en   = 1'b0;
        d    = RV;
        clr1 = 1'b0;
        en1  = 1'b0;
        d1   = 1'b0;

        // threshold rise/fall on ch1
        add(1, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0111, 4'b0111, 4'b0010, 4'b0000);
        add(1, 0, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0111, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0111, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0111, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0010);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        // glitch rejection on ch3: 1,1,1,0,0,0,1,1,1,0
        add(1, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        // hysteresis on ch2 from q=1: 0,0,0,1,1,1
        add(1, 0, 4'b0001, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0001, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0001, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        // enable gating on ch1: rise 7 edges after first enabled sample
        add(1, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(0, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(0, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(0, 0, 4'b0111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b0111, 4'b0111, 4'b0010, 4'b0000);
        add(0, 0, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
        // clear priority with ch3 at cnt=3 and ch1 at q=1
        add(1, 0, 4'b1111, 4'b0111, 4'b0000, 4'b0000);
        add(1, 0, 4'b1111, 4'b0111, 4'b0000, 4'b0000);
        add(1, 0, 4'b1111, 4'b0111, 4'b0000, 4'b0000);
        add(1, 1, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4'b1111, 4'b1111, 4'b1010, 4'b0000);

        #2;
        check("reset q", q, RV);
        check("reset rise", rise, 4'b0000);
        check("reset fall", fall, 4'b0000);
        check("reset s1 q", {3'b000, q1}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < SIZE + LAT; i++) step(1, 0, 4'b1010);
        check("swing q", q, 4'b1010);
        check("swing rise", rise, 4'b1010);
        check("swing fall", fall, 4'b0101);
        #2 rst = 1'b1;
        #1;
        check("async rst q", q, RV);
        check("async rst rise", rise, 4'b0000);
        check("async rst fall", fall, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, RV);
            check($sformatf("idle%0d q", i), q, RV);
            check($sformatf("idle%0d rise", i), rise, 4'b0000);
            check($sformatf("idle%0d fall", i), fall, 4'b0000);
        end

        for (int j = 0; j < LAT; j++) step(0, 0, tbl[j].d);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i + LAT < tbl.size()) dsel = tbl[i + LAT].d;
            else dsel = tbl[tbl.size() - 1].d;
            step(tbl[i].en, tbl[i].clr, dsel);
            check($sformatf("row%0d q", i), q, tbl[i].q);
            check($sformatf("row%0d rise", i), rise, tbl[i].r);
            check($sformatf("row%0d fall", i), fall, tbl[i].f);
        end

        en = 1'b0;
        pat = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0};
        for (int k = 0; k < 12; k++) begin
            d1  = pat[k];
            en1 = 1'b1;
            @(posedge clk);
            #1;
            eq1 = (k - LAT >= 0) ? pat[k - LAT] : 1'b0;
            pq1 = (k - 1 - LAT >= 0) ? pat[k - 1 - LAT] : 1'b0;
            check($sformatf("s1 e%0d q", k), {3'b000, q1}, {3'b000, eq1});
            check($sformatf("s1 e%0d rise", k), {3'b000, r1},
                  {3'b000, eq1 & ~pq1});
            check($sformatf("s1 e%0d fall", k), {3'b000, f1},
                  {3'b000, ~eq1 & pq1});
        end
        en1 = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 200; i++) begin
            dv[0] = 1'($urandom_range(0, 1));
            dv[1] = (i % 3) == 0;
            dv[2] = ((i / 6) % 2) == 1;
            dv[3] = ($urandom_range(0, 3) != 0);
            e     = ($urandom_range(0, 7) != 0);
            c     = ($urandom_range(0, 63) == 0);
            model_step(e, c, dv);
            step(e, c, dv);
            check($sformatf("mdl%0d q", i), q, mq);
            check($sformatf("mdl%0d rise", i), rise, mr);
            check($sformatf("mdl%0d fall", i), fall, mf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
